wb_port_user_proj: RTL and testbench
====================================

WB_PORT_USER_PROJ -- requirements
Module: wb_port_user_proj

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address of the block; it is decoded on wbs_adr_i[31:8].
REQ-002 Parameter ID_VALUE, default 32'hAB60_0001, constant returned by the ID register.
REQ-003 Port wb_clk_i, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-004 Port wb_rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Ports wbs_stb_i and wbs_cyc_i, input, 1 bit each: Wishbone strobe and cycle.
REQ-006 Port wbs_we_i, input, 1 bit: write enable.
REQ-007 Port wbs_sel_i, input, 4 bits: byte selects.
REQ-008 Ports wbs_adr_i and wbs_dat_i, input, 32 bits each: address and write data.
REQ-009 Port wbs_ack_o, output, 1 bit: acknowledge.
REQ-010 Port wbs_dat_o, output, 32 bits: read data.
REQ-011 Ports io_in, io_out and io_oeb: io_in is an input, io_out and io_oeb are outputs, each 38 bits: pad in, pad out, and pad output-enable (active-low).
REQ-012 Port irq, output, 3 bits: interrupt lines to the management core.

Function
REQ-013 Access condition: stb&cyc with wbs_adr_i[31:8]==BASE_ADDR[31:8]; any other address produces no ack.
REQ-014 Ack timing: wbs_ack_o is a one-cycle pulse on the cycle after the access condition; a new access is accepted only while ack is low, so ack is never high on consecutive cycles.
REQ-015 wbs_dat_o is valid while ack is high and reads 0 otherwise.
REQ-016 Writes apply only to bytes whose wbs_sel_i bit is set, and take effect on the ack edge.
REQ-017 Register map, selected by wbs_adr_i[7:0]; any unmapped offset is acked, reads 0 and ignores writes:
- 0x00 CTRL (rw): bit0 count_en, bit1 irq_en, bit2 out_en; bits [31:3] read 0.
- 0x04 COUNT (rw): 32-bit counter.
- 0x08 OUT (rw): bits [15:0] only; bits [31:16] read 0.
- 0x0C IN (ro): io_in[37:0] mapped as {io_in[31:0]}.
- 0x10 MATCH (rw): compare value.
- 0x14 STATUS: bit0 is the sticky match flag, write-1-to-clear.
- 0x18 ID (ro): ID_VALUE.
REQ-018 COUNT increments by 1 each cycle while count_en=1 and wraps from 32'hFFFF_FFFF to 0.
REQ-019 A COUNT write has priority over the increment in the same cycle.
REQ-020 io_out[31:16] = OUT[15:0] registered, so it is visible the cycle after the write ack; all other io_out bits are 0.
REQ-021 io_oeb[31:16] = {16{~out_en}}; all other io_oeb bits are 1.
REQ-022 The match flag sets on the cycle after COUNT==MATCH while count_en=1.
REQ-023 When a set and a W1C clear of the match flag coincide, the set wins.
REQ-024 irq[0] = match flag & irq_en; irq[2:1] = 0.

Reset
REQ-025 On wb_rst_i=1, immediately and independent of the clock, all registers clear to 0.
REQ-026 During reset: wbs_ack_o=0, wbs_dat_o=0, io_out=0, io_oeb all 1, irq=0.
REQ-027 Reset asserted mid-access aborts the access, with no ack and no write.

Configuration
REQ-028 Macro WB_PORT_IRQ_EN defined: the MATCH register, the STATUS register, the match flag and irq[0] are implemented as above.
REQ-029 Macro WB_PORT_IRQ_EN undefined: no match/STATUS logic; MATCH and STATUS read 0 and ignore writes; irq=0; CTRL bit1 reads 0.

Structure
REQ-030 Package wb_port_pkg holds the register offset constants, CTRL bit index constants, and the default ID constant.
REQ-031 The counter plus match logic is a single sub-module, wb_port_counter, with inputs clk, rst, en, load, load_val, match_val and outputs count and hit.

Verification
REQ-032 Write 0x0000_0004 to CTRL, then 0x0000_AB60 to OUT -> io_oeb[31:16]=0 and io_out[31:16]=16'hAB60 the cycle after the ack; then write 0xAB61 -> io_out[31:16]=16'hAB61.
REQ-033 Read ID -> 32'hAB60_0001 with a single-cycle ack; read an address with adr[31:8]=0x300001 -> no ack within 16 cycles.
REQ-034 Write COUNT=32'hFFFF_FFFE, then set count_en=1 -> COUNT reads wrap through 0.
REQ-035 Write COUNT=5 on the same cycle an increment would occur -> COUNT reads 5 followed by increments from 5.
REQ-036 With WB_PORT_IRQ_EN defined: MATCH=100, irq_en=1, count_en=1 from COUNT=0 -> irq[0] rises the cycle after COUNT=100; write 1 to STATUS -> irq[0]=0.
REQ-037 Byte-select write of 0xFFFF_FFFF to OUT with sel=4'b0001 -> OUT reads 0x0000_00FF; asserting wb_rst_i mid-access -> no ack and all outputs at their reset values.

Source files
------------

// File: rtl/wb_port_pkg.sv
// Shared constants for the Wishbone user-project port: register offsets,
// CTRL bit positions, the default ID word and a byte-lane merge helper.
package wb_port_pkg;

   localparam logic [7:0] OFS_CTRL   = 8'h00;
   localparam logic [7:0] OFS_COUNT  = 8'h04;
   localparam logic [7:0] OFS_OUT    = 8'h08;
   localparam logic [7:0] OFS_IN     = 8'h0C;
   localparam logic [7:0] OFS_MATCH  = 8'h10;
   localparam logic [7:0] OFS_STATUS = 8'h14;
   localparam logic [7:0] OFS_ID     = 8'h18;

   localparam int CTRL_COUNT_EN = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_OUT_EN   = 2;

   localparam logic [31:0] DEFAULT_ID = 32'hAB60_0001;

   // Replace only the byte lanes whose select bit is set.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_port_counter.sv
// Free-running 32-bit counter with load and an equality compare.
// A load wins over the increment; hit flags count==match_val while enabled.
module wb_port_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic [31:0] match_val,
   output logic [31:0] count,
   output logic        hit
);

   logic [31:0] count_q, count_d;

   // Next count: load has priority, otherwise increment (wrapping) when enabled.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en) begin
         count_d = count_q + 32'd1;
      end
   end

   // Counter state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;
   assign hit   = en && (count_q == match_val);

endmodule

// File: rtl/wb_port_user_proj.sv
// Wishbone slave exposing a control register, a counter, a 16-bit pad output
// port, a pad input view and an ID word. Optional compare/interrupt logic
// (MATCH, STATUS, irq[0]) is built only when WB_PORT_IRQ_EN is defined.
module wb_port_user_proj
   import wb_port_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter logic [31:0] ID_VALUE  = DEFAULT_ID
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic [37:0] io_in,
   output logic [37:0] io_out,
   output logic [37:0] io_oeb,
   output logic [2:0]  irq
);

`ifdef WB_PORT_IRQ_EN
   localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
   localparam logic [2:0] CTRL_WMASK = 3'b101;
`endif

   logic        ack_q, ack_d;
   logic [31:0] dat_q, dat_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [15:0] out_q, out_d;
   logic [15:0] io_out_q, io_out_d;

   logic        access, wr;
   logic [7:0]  offset;
   logic [31:0] rdata;
   logic [31:0] ctrl_wval, out_wval, count_wval;
   logic [31:0] count, match_val;
   logic        cnt_load, cnt_hit;
   logic        unused_sink;

`ifdef WB_PORT_IRQ_EN
   logic [31:0] match_q, match_d;
   logic        flag_q, flag_d;
   logic        flag_clr;
   logic [31:0] match_wval;
`endif

   // A new access is taken only while ack is low, so acks never run back to back.
   assign access = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:8] == BASE_ADDR[31:8]) && !ack_q;
   assign wr     = access && wbs_we_i;
   assign offset = wbs_adr_i[7:0];

   assign ctrl_wval  = merge_bytes({29'b0, ctrl_q}, wbs_dat_i, wbs_sel_i);
   assign out_wval   = merge_bytes({16'b0, out_q}, wbs_dat_i, wbs_sel_i);
   assign count_wval = merge_bytes(count, wbs_dat_i, wbs_sel_i);

`ifdef WB_PORT_IRQ_EN
   assign match_wval  = merge_bytes(match_q, wbs_dat_i, wbs_sel_i);
   assign match_val   = match_q;
   assign unused_sink = ^{io_in[37:32], ctrl_wval[31:3], out_wval[31:16]};
`else
   assign match_val   = '0;
   assign unused_sink = ^{io_in[37:32], ctrl_wval[31:3], out_wval[31:16], cnt_hit};
`endif

   wb_port_counter u_counter (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .en        (ctrl_q[CTRL_COUNT_EN]),
      .load      (cnt_load),
      .load_val  (count_wval),
      .match_val (match_val),
      .count     (count),
      .hit       (cnt_hit)
   );

   // Register read mux; unmapped offsets read 0.
   always_comb begin
      rdata = '0;
      case (offset)
         OFS_CTRL:   rdata = {29'b0, ctrl_q};
         OFS_COUNT:  rdata = count;
         OFS_OUT:    rdata = {16'b0, out_q};
         OFS_IN:     rdata = io_in[31:0];
`ifdef WB_PORT_IRQ_EN
         OFS_MATCH:  rdata = match_q;
         OFS_STATUS: rdata = {31'b0, flag_q};
`endif
         OFS_ID:     rdata = ID_VALUE;
         default:    rdata = '0;
      endcase
   end

   // Bus response and register write decode; writes land on the edge that raises ack.
   always_comb begin
      ack_d    = access;
      dat_d    = (access && !wbs_we_i) ? rdata : '0;
      ctrl_d   = ctrl_q;
      out_d    = out_q;
      io_out_d = out_q;
      cnt_load = 1'b0;
`ifdef WB_PORT_IRQ_EN
      match_d  = match_q;
      flag_clr = 1'b0;
`endif
      if (wr) begin
         case (offset)
            OFS_CTRL:   ctrl_d   = ctrl_wval[2:0] & CTRL_WMASK;
            OFS_COUNT:  cnt_load = 1'b1;
            OFS_OUT:    out_d    = out_wval[15:0];
`ifdef WB_PORT_IRQ_EN
            OFS_MATCH:  match_d  = match_wval;
            OFS_STATUS: flag_clr = wbs_sel_i[0] && wbs_dat_i[0];
`endif
            default:    ;
         endcase
      end
`ifdef WB_PORT_IRQ_EN
      // A coincident set beats the write-1-to-clear.
      flag_d = cnt_hit || (flag_q && !flag_clr);
`endif
   end

   // State registers, cleared asynchronously by reset.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         ctrl_q   <= '0;
         out_q    <= '0;
         io_out_q <= '0;
`ifdef WB_PORT_IRQ_EN
         match_q  <= '0;
         flag_q   <= 1'b0;
`endif
      end else begin
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         ctrl_q   <= ctrl_d;
         out_q    <= out_d;
         io_out_q <= io_out_d;
`ifdef WB_PORT_IRQ_EN
         match_q  <= match_d;
         flag_q   <= flag_d;
`endif
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign io_out    = {6'b0, io_out_q, 16'b0};
   assign io_oeb    = {6'h3F, {16{~ctrl_q[CTRL_OUT_EN]}}, 16'hFFFF};

`ifdef WB_PORT_IRQ_EN
   assign irq = {2'b00, flag_q && ctrl_q[CTRL_IRQ_EN]};
`else
   assign irq = 3'b000;
`endif

endmodule

// File: tb/tb_wb_port_user_proj.sv
// Directed bench for wb_port_user_proj; the compare/interrupt section is
// exercised when WB_PORT_IRQ_EN is defined, its absence otherwise.
module tb_wb_port_user_proj;

   logic        clk = 1'b0;
   logic        rst;
   logic        stb, cyc, we;
   logic [3:0]  sel;
   logic [31:0] adr, wdat;
   logic        ack;
   logic [31:0] rdat_o;
   logic [37:0] io_in, io_out, io_oeb;
   logic [2:0]  irq;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fail_cnt  = 0;

   localparam logic [37:0] OEB_RESET = 38'h3F_FFFF_FFFF;
   localparam logic [37:0] OEB_OUTEN = 38'h3F_0000_FFFF;

   wb_port_user_proj dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (wdat),
      .wbs_ack_o (ack),
      .wbs_dat_o (rdat_o),
      .io_in     (io_in),
      .io_out    (io_out),
      .io_oeb    (io_oeb),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One bus transfer; returns read data and whether an ack came within 16 cycles.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic acked);
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
      acked = 1'b0;
      rd = '0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            acked = 1'b1;
            rd = rdat_o;
            break;
         end
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] rd;
      logic        ak;
      xfer(1'b1, a, d, 4'hF, rd, ak);
      chk("write_ack", 64'(ak), 64'd1);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      logic        ak;
      xfer(1'b0, a, 32'h0, 4'hF, rd, ak);
      chk(tag, {31'b0, ak, rd}, {31'b0, 1'b1, exp});
   endtask

   initial begin
      logic [31:0] rd;
      logic        ak;
      int          n;

      rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
      adr = '0; wdat = '0; io_in = '0;

      // Outputs while held in reset
      #12;
      chk("rst_ack",    64'(ack),    64'd0);
      chk("rst_dat",    64'(rdat_o), 64'd0);
      chk("rst_io_out", 64'(io_out), 64'd0);
      chk("rst_io_oeb", 64'(io_oeb), 64'(OEB_RESET));
      chk("rst_irq",    64'(irq),    64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      rd_chk("ctrl_after_rst",  32'h3000_0000, 32'h0);
      rd_chk("count_after_rst", 32'h3000_0004, 32'h0);

      // Output enable and pad output path
      wr(32'h3000_0000, 32'h0000_0004);
      chk("oeb_enabled", 64'(io_oeb), 64'(OEB_OUTEN));
      wr(32'h3000_0008, 32'h0000_AB60);
      chk("io_out_not_yet", 64'(io_out), 64'd0);
      @(posedge clk); #1;
      chk("io_out_ab60", 64'(io_out), 64'(38'h00_AB60_0000));
      wr(32'h3000_0008, 32'h0000_AB61);
      @(posedge clk); #1;
      chk("io_out_ab61", 64'(io_out), 64'(38'h00_AB61_0000));
      rd_chk("out_read", 32'h3000_0008, 32'h0000_AB61);

      // ID read, single-cycle ack, data returns to 0 after ack
      rd_chk("id_read", 32'h3000_0018, 32'hAB60_0001);
      @(posedge clk); #1;
      chk("ack_single_cycle", 64'(ack), 64'd0);
      chk("dat_zero_no_ack", 64'(rdat_o), 64'd0);

      // Foreign address is never acked
      xfer(1'b0, 32'h3000_0100, 32'h0, 4'hF, rd, ak);
      chk("foreign_no_ack", 64'(ak), 64'd0);

      // Pad input view and unmapped offset
      io_in = 38'h2A_1234_5678;
      rd_chk("in_read", 32'h3000_000C, 32'h1234_5678);
      wr(32'h3000_001C, 32'hFFFF_FFFF);
      rd_chk("unmapped_read", 32'h3000_001C, 32'h0);

      // Counter wrap: reads sample the count two cycles apart
      wr(32'h3000_0004, 32'hFFFF_FFFE);
      wr(32'h3000_0000, 32'h0000_0005);
      rd_chk("count_pre_wrap",  32'h3000_0004, 32'hFFFF_FFFF);
      rd_chk("count_post_wrap", 32'h3000_0004, 32'h0000_0001);

      // Load while counting: load wins, then counting resumes from 5
      wr(32'h3000_0004, 32'h0000_0005);
      rd_chk("count_load_5a", 32'h3000_0004, 32'h0000_0006);
      rd_chk("count_load_5b", 32'h3000_0004, 32'h0000_0008);

      // CTRL bit1 and the match registers
      wr(32'h3000_0000, 32'h0000_0007);
      wr(32'h3000_0010, 32'h0000_0064);
`ifdef WB_PORT_IRQ_EN
      rd_chk("ctrl_all_bits", 32'h3000_0000, 32'h0000_0007);
      rd_chk("match_read",    32'h3000_0010, 32'h0000_0064);

      wr(32'h3000_0000, 32'h0000_0000);
      wr(32'h3000_0004, 32'h0000_0000);
      wr(32'h3000_0014, 32'h0000_0001);
      chk("irq_cleared_pre", 64'(irq), 64'd0);
      wr(32'h3000_0000, 32'h0000_0003);
      n = 0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         if (irq[0]) begin
            n = i;
            break;
         end
      end
      chk("irq_rise_cycle", 64'(n), 64'd101);
      rd_chk("status_set", 32'h3000_0014, 32'h0000_0001);
      wr(32'h3000_0014, 32'h0000_0001);
      chk("irq_after_w1c", 64'(irq), 64'd0);
`else
      rd_chk("ctrl_bit1_zero", 32'h3000_0000, 32'h0000_0005);
      chk("irq_absent", 64'(irq), 64'd0);
      rd_chk("match_absent",  32'h3000_0010, 32'h0);
      rd_chk("status_absent", 32'h3000_0014, 32'h0);
`endif

      // Byte-lane write
      wr(32'h3000_0000, 32'h0000_0004);
      wr(32'h3000_0008, 32'h0000_0000);
      xfer(1'b1, 32'h3000_0008, 32'hFFFF_FFFF, 4'b0001, rd, ak);
      chk("byte_write_ack", 64'(ak), 64'd1);
      rd_chk("byte_write_out", 32'h3000_0008, 32'h0000_00FF);

      // Reset in the middle of an access
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3000_0008; wdat = 32'h0000_1234; sel = 4'hF;
      #3;
      rst = 1'b1;
      #1;
      chk("midrst_ack",    64'(ack),    64'd0);
      chk("midrst_dat",    64'(rdat_o), 64'd0);
      chk("midrst_io_out", 64'(io_out), 64'd0);
      chk("midrst_io_oeb", 64'(io_oeb), 64'(OEB_RESET));
      chk("midrst_irq",    64'(irq),    64'd0);
      @(posedge clk); #1;
      chk("midrst_ack_edge", 64'(ack), 64'd0);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      rst = 1'b0;
      rd_chk("midrst_out_clear",  32'h3000_0008, 32'h0);
      rd_chk("midrst_ctrl_clear", 32'h3000_0000, 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
